// File: rtl/matrix_stream_gen.sv
// Row-major M x N matrix source over a valid/ready stream with random, zero,
// identity and constant fill; random values come from a reseedable 32-bit LFSR.
module matrix_stream_gen #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIM_W  = 3,
   parameter logic [31:0] SEED   = 32'hACE1ACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [DIM_W-1:0]  dim_m,
   input  logic [DIM_W-1:0]  dim_n,
   input  logic [DATA_W-1:0] elem_min,
   input  logic [DATA_W-1:0] elem_max,
   input  logic              seed_load,
   input  logic [31:0]       seed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [DIM_W-1:0]  out_row,
   output logic [DIM_W-1:0]  out_col,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] MODE_RAND  = 2'd0;
   localparam logic [1:0] MODE_ID    = 2'd2;
   localparam logic [1:0] MODE_CONST = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [31:0]         lfsr, lfsr_nx;
   logic [1:0]          cfg_mode, cfg_mode_nx;
   logic [DIM_W-1:0]    cfg_m, cfg_m_nx;
   logic [DIM_W-1:0]    cfg_n, cfg_n_nx;
   logic [DATA_W-1:0]   cfg_min, cfg_min_nx;
   logic [DATA_W-1:0]   cfg_max, cfg_max_nx;
   logic                valid_nx;
   logic [DATA_W-1:0]   data_nx;
   logic [DIM_W-1:0]    row_nx, col_nx;
   logic                last_nx, busy_nx, done_nx, err_nx;
   logic [31:0]         lfsr_l0, lfsr_first, lfsr_run;
   logic                cfg_bad;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
   endfunction

   // Range is one bit wider so a full-span range is 2^DATA_W rather than zero.
   function automatic logic [DATA_W-1:0] rand_value(input logic [31:0]       l,
                                                    input logic [DATA_W-1:0] lo,
                                                    input logic [DATA_W-1:0] hi);
      logic [DATA_W:0] range_w;
      logic [DATA_W:0] sum_w;
      range_w = {1'b0, hi} - {1'b0, lo} + (DATA_W+1)'(1);
      sum_w   = {1'b0, lo} + ({1'b0, l[DATA_W-1:0]} % range_w);
      return sum_w[DATA_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] fill_value(input logic [1:0]        md,
                                                    input logic [DIM_W-1:0]  r,
                                                    input logic [DIM_W-1:0]  c,
                                                    input logic [DATA_W-1:0] k);
      logic [DATA_W-1:0] v;
      v = '0;
      if (md == MODE_ID)
         v = DATA_W'(r == c);
      else if (md == MODE_CONST)
         v = k;
      return v;
   endfunction

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         lfsr      <= SEED;
         cfg_mode  <= '0;
         cfg_m     <= '0;
         cfg_n     <= '0;
         cfg_min   <= '0;
         cfg_max   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         lfsr      <= lfsr_nx;
         cfg_mode  <= cfg_mode_nx;
         cfg_m     <= cfg_m_nx;
         cfg_n     <= cfg_n_nx;
         cfg_min   <= cfg_min_nx;
         cfg_max   <= cfg_max_nx;
         out_valid <= valid_nx;
         out_data  <= data_nx;
         out_row   <= row_nx;
         out_col   <= col_nx;
         out_last  <= last_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         err       <= err_nx;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx    = state;
      lfsr_nx     = lfsr;
      cfg_mode_nx = cfg_mode;
      cfg_m_nx    = cfg_m;
      cfg_n_nx    = cfg_n;
      cfg_min_nx  = cfg_min;
      cfg_max_nx  = cfg_max;
      valid_nx    = out_valid;
      data_nx     = out_data;
      row_nx      = out_row;
      col_nx      = out_col;
      last_nx     = out_last;
      err_nx      = 1'b0;
      lfsr_l0     = seed_load ? ((seed == 32'd0) ? SEED : seed) : lfsr;
      lfsr_first  = lfsr_step(lfsr_l0);
      lfsr_run    = lfsr_step(lfsr);
      cfg_bad     = (dim_m == '0) || (dim_n == '0) ||
                    ((mode == MODE_RAND) && (elem_min > elem_max));

      unique case (state)
         S_IDLE: begin
            if (seed_load)
               lfsr_nx = lfsr_l0;
            if (start) begin
               if (cfg_bad) begin
                  err_nx = 1'b1;
               end else begin
                  state_nx    = S_RUN;
                  cfg_mode_nx = mode;
                  cfg_m_nx    = dim_m;
                  cfg_n_nx    = dim_n;
                  cfg_min_nx  = elem_min;
                  cfg_max_nx  = elem_max;
                  row_nx      = '0;
                  col_nx      = '0;
                  valid_nx    = 1'b1;
                  last_nx     = (dim_m == DIM_W'(1)) && (dim_n == DIM_W'(1));
                  if (mode == MODE_RAND) begin
                     lfsr_nx = lfsr_first;
                     data_nx = rand_value(lfsr_first, elem_min, elem_max);
                  end else begin
                     data_nx = fill_value(mode, DIM_W'(0), DIM_W'(0), elem_min);
                  end
               end
            end
         end
         S_RUN: begin
            if (out_valid && out_ready) begin
               if (out_last) begin
                  valid_nx = 1'b0;
                  last_nx  = 1'b0;
                  state_nx = S_DONE;
               end else begin
                  if (out_col == cfg_n - DIM_W'(1)) begin
                     col_nx = '0;
                     row_nx = out_row + DIM_W'(1);
                  end else begin
                     col_nx = out_col + DIM_W'(1);
                  end
                  last_nx = (row_nx == cfg_m - DIM_W'(1)) && (col_nx == cfg_n - DIM_W'(1));
                  if (cfg_mode == MODE_RAND) begin
                     lfsr_nx = lfsr_run;
                     data_nx = rand_value(lfsr_run, cfg_min, cfg_max);
                  end else begin
                     data_nx = fill_value(cfg_mode, row_nx, col_nx, cfg_min);
                  end
               end
            end
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      busy_nx = (state_nx != S_IDLE);
      done_nx = (state_nx == S_DONE);
   end

endmodule

// File: tb/tb_matrix_stream_gen.sv
// Directed bench for matrix_stream_gen: a matrix-level reference model fills an
// expected-beat queue that one negedge process compares against the stream.
module tb_matrix_stream_gen;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DIM_W  = 3;
   localparam logic [31:0] SEED   = 32'hACE1ACE1;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, seed_load, out_ready;
   logic [1:0]        mode;
   logic [DIM_W-1:0]  dim_m, dim_n;
   logic [DATA_W-1:0] elem_min, elem_max;
   logic [31:0]       seed;
   logic              out_valid, out_last, busy, done, err;
   logic [DATA_W-1:0] out_data;
   logic [DIM_W-1:0]  out_row, out_col;

   always #5 clk = ~clk;

   matrix_stream_gen #(.DATA_W(DATA_W), .DIM_W(DIM_W), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .dim_m(dim_m), .dim_n(dim_n),
      .elem_min(elem_min), .elem_max(elem_max), .seed_load(seed_load), .seed(seed),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .busy(busy), .done(done), .err(err));

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [DIM_W-1:0]  row;
      logic [DIM_W-1:0]  col;
      logic              last;
   } beat_t;

   beat_t             exp_q[$];
   logic [DATA_W-1:0] got_q[$];
   logic [DATA_W-1:0] saved_q[$];
   int                vectors = 0;
   int                miscompares = 0;
   logic [31:0]       m_lfsr;
   bit                chk_en = 1'b0;

   function automatic logic [31:0] m_step(input logic [31:0] x);
      return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: whole matrix in row-major order, LFSR advanced once per element.
   task automatic build(input int md, input int m, input int n, input int mn, input int mx);
      beat_t b;
      int    lb, d;
      for (int r = 0; r < m; r++) begin
         for (int c = 0; c < n; c++) begin
            case (md)
               0: begin
                  m_lfsr = m_step(m_lfsr);
                  lb = int'(m_lfsr[7:0]);
                  d  = mn + (lb % (mx - mn + 1));
               end
               2: d = (r == c) ? 1 : 0;
               3: d = mn;
               default: d = 0;
            endcase
            b.data = DATA_W'(d);
            b.row  = DIM_W'(r);
            b.col  = DIM_W'(c);
            b.last = (r == m - 1) && (c == n - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   // Compare every presented beat; a beat leaves the queue once it is accepted.
   always @(negedge clk) begin
      if (chk_en && !rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(out_valid), 64'd0);
         end else begin
            check("beat_data", 64'(out_data), 64'(exp_q[0].data));
            check("beat_rc_last", 64'({out_row, out_col, out_last}),
                  64'({exp_q[0].row, exp_q[0].col, exp_q[0].last}));
            check("busy_with_valid", 64'(busy), 64'd1);
            if (out_ready) begin
               got_q.push_back(out_data);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic run(input int md, input int m, input int n, input int mn, input int mx,
                      input logic [3:0] rpat, input bit ld, input logic [31:0] sd,
                      input string tag);
      int cyc, nvalid;
      if (ld) m_lfsr = (sd == 32'd0) ? SEED : sd;
      got_q.delete();
      build(md, m, n, mn, mx);
      mode = 2'(md); dim_m = DIM_W'(m); dim_n = DIM_W'(n);
      elem_min = DATA_W'(mn); elem_max = DATA_W'(mx);
      seed_load = ld; seed = sd; start = 1'b1; out_ready = rpat[0];
      @(posedge clk); #1;
      start = 1'b0; seed_load = 1'b0;
      mode = 2'($urandom); dim_m = DIM_W'($urandom); dim_n = DIM_W'($urandom);
      elem_min = DATA_W'($urandom); elem_max = DATA_W'($urandom); seed = $urandom;
      check({tag, "_valid_first"}, 64'(out_valid), 64'd1);
      cyc = 0; nvalid = 0;
      while (!done && cyc < 300) begin
         out_ready = rpat[cyc % 4];
         if (out_valid) nvalid++;
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_done_seen"}, 64'(done), 64'd1);
      check({tag, "_valid_at_done"}, 64'(out_valid), 64'd0);
      check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
      if (rpat == 4'b1111) begin
         check({tag, "_valid_cycles"}, 64'(nvalid), 64'(m * n));
         check({tag, "_done_latency"}, 64'(cyc), 64'(m * n));
      end
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_busy_idle"}, 64'(busy), 64'd0);
      exp_q.delete();
      out_ready = 1'b1;
   endtask

   task automatic bad_start(input int md, input int m, input int n, input int mn, input int mx,
                            input string tag);
      mode = 2'(md); dim_m = DIM_W'(m); dim_n = DIM_W'(n);
      elem_min = DATA_W'(mn); elem_max = DATA_W'(mx); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_err"}, 64'(err), 64'd1);
      check({tag, "_busy"}, 64'({busy, out_valid}), 64'd0);
      @(posedge clk); #1;
      check({tag, "_err_pulse"}, 64'(err), 64'd0);
      check({tag, "_still_idle"}, 64'({busy, out_valid}), 64'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
      mode = '0; dim_m = '0; dim_n = '0; elem_min = '0; elem_max = '0; seed = '0;
      m_lfsr = SEED;
      #1 rst = 1'b1;
      #1;
      check("reset_outputs", 64'({out_valid, out_data, out_row, out_col, out_last, busy, done, err}), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      chk_en = 1'b1;

      run(2, 3, 3, 0, 0, 4'b1111, 1'b0, 32'd0, "ident3x3");
      check("ident_b0", 64'(got_q[0]), 64'd1);
      check("ident_b1", 64'(got_q[1]), 64'd0);
      check("ident_b4", 64'(got_q[4]), 64'd1);
      check("ident_b8", 64'(got_q[8]), 64'd1);

      run(0, 2, 4, 10, 12, 4'b1001, 1'b1, 32'h1, "rand_stall");
      check("rand_lit_b0", 64'(got_q[0]), 64'd10);
      check("rand_lit_b1", 64'(got_q[1]), 64'd10);
      check("rand_lit_b2", 64'(got_q[2]), 64'd11);
      check("rand_lit_b3", 64'(got_q[3]), 64'd10);
      saved_q = got_q;
      run(0, 2, 4, 10, 12, 4'b1111, 1'b1, 32'h1, "rand_ready");
      for (int i = 0; i < 8; i++)
         check("rand_ready_indep", 64'(got_q[i]), 64'(saved_q[i]));

      run(0, 1, 5, 0, 255, 4'b1111, 1'b1, 32'h12345678, "rand_full");
      check("full_lit_b0", 64'(got_q[0]), 64'd241);

      bad_start(2, 0, 3, 0, 0, "dim_zero");
      bad_start(0, 2, 2, 20, 5, "min_gt_max");
      run(3, 2, 2, 20, 5, 4'b1111, 1'b0, 32'd0, "const_inv");
      check("const_lit", 64'(got_q[3]), 64'd20);
      run(0, 1, 2, 0, 255, 4'b1111, 1'b0, 32'd0, "after_err");

      seed_load = 1'b1; seed = 32'd0;
      @(posedge clk); #1 seed_load = 1'b0;
      m_lfsr = SEED;
      run(0, 1, 2, 0, 255, 4'b1111, 1'b0, 32'd0, "seed_zero");
      check("seed_zero_lit", 64'(got_q[0]), 64'hC3);
      run(0, 1, 3, 0, 255, 4'b1111, 1'b1, 32'h1, "seed_same_cycle");
      check("seed_same_lit", 64'(got_q[0]), 64'd3);

      // Reset while beat 3 of a 4x4 matrix is on the bus
      build(1, 4, 4, 0, 0);
      mode = 2'd1; dim_m = 3'd4; dim_n = 3'd4; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_row_col", 64'({out_row, out_col}), 64'({3'd0, 3'd2}));
      #1 rst = 1'b1;
      #1;
      check("rst_mid_outputs", 64'({out_valid, out_data, out_row, out_col, out_last, busy, done, err}), 64'd0);
      exp_q.delete();
      m_lfsr = SEED;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_no_done", 64'({done, busy}), 64'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      run(1, 2, 2, 0, 0, 4'b1111, 1'b0, 32'd0, "zero_after_rst");
      run(0, 1, 3, 0, 255, 4'b1111, 1'b0, 32'd0, "rand_after_rst");
      check("rst_lfsr_lit", 64'(got_q[0]), 64'hC3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/matrix_stream_gen.md
# matrix_stream_gen

Parametrised matrix source for the matrix calculator datapath. It emits an M×N matrix in row-major order over a valid/ready stream, one element per accepted beat, tagged with row/column indices and a last flag. It supports uniform-random (LFSR-driven, reseedable), zero, identity and constant fill modes, and sits between the configuration/UI logic and the matrix storage/compute units.

## Interface
- DATA_W, 8: element width, unsigned.
- DIM_W, 3: dimension/index width; legal dims 1..2^DIM_W−1.
- SEED, 32'hACE1ACE1: reset LFSR value; also substituted for any loaded zero seed.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  start request; sampled only in IDLE.
- mode  in  2  0 random, 1 zero, 2 identity, 3 constant (elem_min).
- dim_m, dim_n  in  DIM_W  rows, columns.
- elem_min, elem_max  in  DATA_W  inclusive random range.
- seed_load  in  1  load seed into LFSR; honoured only in IDLE.
- seed  in  32  seed value.
- out_valid  out  1  element present.
- out_ready  in  1  sink accepts.
- out_data  out  DATA_W  element value.
- out_row, out_col  out  DIM_W  element indices.
- out_last  out  1  element (M−1, N−1).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle bad-configuration pulse.

## Operation
- Reset: state IDLE; all outputs 0; LFSR = SEED; config registers 0.
- LFSR: 32-bit, shift left, bit0 ← l[31]^l[21]^l[1]^l[0]. step(x) means one shift.
- States: IDLE, RUN, DONE.
- IDLE, seed_load=1: LFSR ← (seed==0 ? SEED : seed).
- IDLE, start=1: latch mode, dims, min and max.
  - If dim_m==0, dim_n==0, or (mode==0 and elem_min>elem_max): pulse err, stay IDLE, LFSR unchanged.
  - Otherwise go to RUN with row=col=0 and out_valid←1.
- start while busy: ignored, with no err.
- Random value from LFSR state L:
  - range = max−min+1, computed in DATA_W+1 bits (full span gives 2^DATA_W, never 0).
  - value = min + (L[DATA_W−1:0] mod range), truncated to DATA_W.
- Random mode sequencing:
  - On start, L0 = loaded seed if seed_load is also high that cycle, else the current LFSR.
  - LFSR ← step(L0); out_data ← value(step(L0)).
  - Each accepted non-last beat: LFSR ← step(LFSR); out_data ← value of the new state.
- Other modes: LFSR does not advance. Values are zero → 0; identity → (row==col); constant → elem_min (range unchecked).
- Indices: col increments per accepted beat. At col==N−1, col←0 and row increments.
- out_last = (row==M−1 && col==N−1).
- Last beat accepted: out_valid←0, go to DONE. DONE drives done=1 for one cycle, then returns to IDLE.
- Backpressure: while out_valid && !out_ready, out_data/row/col/last hold stable. The value sequence is independent of out_ready pattern.
- rst mid-run: immediate return to reset values; any partial matrix is abandoned with no done.

## Timing
- start accepted at edge T → first element valid at T+1.
- Throughput: 1 element/cycle with out_ready held high. M×N beats occupy T+1..T+M·N.
- Last transfer at edge E → out_valid=0 and done=1 during E..E+1, then IDLE.
- Earliest next start is sampled the cycle after done.
- err asserts the cycle after the bad start; busy stays 0.
- busy rises with out_valid and falls with done.
- Config inputs are don't-care after the start edge.

## Test plan
- Identity, 3×3, out_ready=1 → data 1,0,0,0,1,0,0,0,1; (row,col) (0,0)…(2,2); out_last only on beat 9; done one cycle after; 9 consecutive valid cycles.
- Random, 2×4, min=10, max=12, seed=32'h1 loaded, ready toggling 1,0,0,1,… → all 8 values in [10,12], outputs stable while stalled; value sequence identical to a ready=1 run with the same seed, and matching a software model of the LFSR/mod.
- Random, 1×5, min=0, max=255 → range 256, no divide-by-zero; value equals LFSR low byte each beat.
- Config errors: dim_m=0; and random with min=20, max=5 → single err pulse each, out_valid and busy never rise; constant mode with min=20, max=5 runs normally (all 20).
- seed_load with seed=0 → LFSR = SEED; start with seed_load high the same cycle uses the new seed.
- rst asserted on beat 3 of 4×4 → all outputs 0 at once, no done; after release, a fresh 2×2 zero run completes normally.
